// File: rtl/reg_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_dump_ctrl_if
//   Output stream of the register dump sequencer: one tagged word per
//   handshake.
//
//   Handshake: a word transfers on a rising clk edge where out_valid and
//   out_ready are both high. Once out_valid is raised, the producer holds
//   out_valid, out_addr, out_data, out_last and out_csum stable until that
//   transfer happens. out_ready may change freely and does not depend on
//   out_valid.
//
//   Signals
//     out_valid  producer -> consumer  word valid
//     out_ready  consumer -> producer  consumer accepts word
//     out_addr   producer -> consumer  register index (0 for checksum word)
//     out_data   producer -> consumer  register value or checksum
//     out_last   producer -> consumer  final word of the dump
//     out_csum   producer -> consumer  word is the checksum word
//   Modports: master = producer (reg_dump_ctrl), slave = consumer.
// -----------------------------------------------------------------------------
interface reg_dump_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_csum;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        output out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        input  out_csum,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// reg_dump_ctrl
//   Read-side sequencer on one read port of the register file. On start it
//   walks first_addr..last_addr (inclusive) and streams each register as one
//   tagged word per cycle over the dout interface. A reversed range produces
//   a one-cycle err pulse together with done and emits nothing.
//
//   Optional feature macro: REG_DUMP_CHECKSUM_EN
//     defined   : after the last register word one extra word carries the XOR
//                 of all emitted data words (out_csum = 1, out_last = 1).
//     undefined : no checksum word; out_csum tied 0; out_last marks the last
//                 register word.
//
//   Ports
//     clk, rst    clock; synchronous active-high reset
//     start       dump request, honoured only in IDLE
//     first_addr  first register of the range, sampled with start
//     last_addr   last register of the range (inclusive), sampled with start
//     raddr       register file read address (always equals cur_addr)
//     rdata       register file read data, combinational from raddr
//     dout        output stream (reg_dump_ctrl_if.master)
//     busy        high in LOAD, SEND, CSUM
//     done        one-cycle pulse in FIN
//     err         one-cycle pulse in FIN on the reversed-range path
//     dbg_state   current FSM state encoding
// -----------------------------------------------------------------------------
module reg_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    reg_dump_ctrl_if.master       dout,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_FIN  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  err_q;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  out_csum_q;
`endif

    logic hs;           // word transfers at the coming edge
    logic at_last;      // word on the bus is the last register of the range
    logic range_ok;
    logic capture;      // load the current register into the output slot
    logic finish_words; // final register word is being accepted

    assign hs       = out_valid_q && dout.out_ready;
    assign at_last  = (out_addr_q == last_q);
    assign range_ok = (first_addr <= last_addr);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        finish_words = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = range_ok ? S_LOAD : S_FIN;
                end
            end
            S_LOAD: begin
                capture = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    if (at_last) begin
                        finish_words = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d      = S_CSUM;
`else
                        state_d      = S_FIN;
`endif
                    end else begin
                        // Capturing on the handshake edge keeps one word per cycle.
                        capture = 1'b1;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (hs) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q  <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
            out_csum_q  <= 1'b0;
`endif
        end else begin
            // err_q is only ever set for the single FIN cycle after a bad start.
            err_q <= 1'b0;

            if (state_q == S_IDLE && start) begin
                if (range_ok) begin
                    last_q     <= last_addr;
                    cur_addr_q <= first_addr;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_q     <= '0;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (capture) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= cur_addr_q;
                out_data_q  <= rdata;
`ifdef REG_DUMP_CHECKSUM_EN
                // The checksum word carries out_last instead.
                out_last_q  <= 1'b0;
                csum_q      <= csum_q ^ rdata;
`else
                out_last_q  <= (cur_addr_q == last_q);
`endif
                // Wraps past the top register; the wrapped value is never captured.
                cur_addr_q  <= cur_addr_q + 1'b1;
            end else if (finish_words) begin
`ifdef REG_DUMP_CHECKSUM_EN
                // Reuse the output slot for the checksum word; out_valid stays high.
                out_addr_q  <= '0;
                out_data_q  <= csum_q;
                out_last_q  <= 1'b1;
                out_csum_q  <= 1'b1;
`else
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            else if (state_q == S_CSUM && hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_csum_q  <= 1'b0;
            end
`endif
        end
    end

    // ------------------------------------------------------------ outputs
    assign raddr          = cur_addr_q;
    assign dout.out_valid = out_valid_q;
    assign dout.out_addr  = out_addr_q;
    assign dout.out_data  = out_data_q;
    assign dout.out_last  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    assign dout.out_csum  = out_csum_q;
    assign busy           = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_CSUM);
`else
    assign dout.out_csum  = 1'b0;
    assign busy           = (state_q == S_LOAD) || (state_q == S_SEND);
`endif
    assign done           = (state_q == S_FIN);
    assign err            = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_ctrl
//   Directed bench for reg_dump_ctrl. The driver computes each expected word
//   (cycle of transfer, flags, address, data) and each expected done pulse
//   and queues them; a negedge monitor pops and compares on every transfer
//   and every done pulse, and checks that words are held stable while
//   out_ready is low. Build with +define+REG_DUMP_CHECKSUM_EN to expect the
//   checksum word.
// -----------------------------------------------------------------------------
module tb_reg_dump_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 16 + 1 + 1 + AW + DW;

    // ------------------------------------------------- clock / reset block
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;
    logic [DW-1:0] rf [32];

    reg_dump_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif ();

    assign rdata = rf[raddr];

    reg_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .raddr      (raddr),
        .rdata      (rdata),
        .dout       (dif),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    logic [EW-1:0] exp_q[$];     // {cycle, csum, last, addr, data}
    logic [16:0]   done_q[$];    // {cycle, err}
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
    endtask

    logic          hold_v = 1'b0;
    logic [38:0]   hold_w;
    logic [EW-1:0] e;
    logic [16:0]   d;

    always @(negedge clk) begin
        if (hold_v) begin
            check("hold_stable",
                  {dif.out_valid, dif.out_csum, dif.out_last, dif.out_addr, dif.out_data},
                  {1'b1, hold_w});
        end
        if (dif.out_valid && dif.out_ready) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_word");
            end else begin
                e = exp_q.pop_front();
                check("word",
                      {cyc[15:0], dif.out_csum, dif.out_last, dif.out_addr, dif.out_data}, e);
            end
        end
        hold_v = dif.out_valid && !dif.out_ready;
        hold_w = {dif.out_csum, dif.out_last, dif.out_addr, dif.out_data};
        if (done) begin
            if (done_q.size() == 0) begin
                flag("unexpected_done");
            end else begin
                d = done_q.pop_front();
                check("done", {cyc[15:0], err}, d);
            end
        end else if (err) begin
            flag("err_without_done");
        end
    end

    // --------------------------------------------------------- driver tasks
    // mode 0: ready always high; mode 1: ready follows 1,0,0,1,0,1 from the
    // first word-valid cycle (offset 2 after the start cycle).
    function automatic bit rdy(input int mode, input int k);
        if (mode == 0 || k < 2) return 1'b1;
        case ((k - 2) % 6)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Called and returns just after a rising edge. abort_k >= 0 asserts rst
    // during offset abort_k; spam holds start high through FIN.
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int mode, input bit spam, input int abort_k);
        int c;
        int t;
        int end_k;
        logic [DW-1:0] x;
        logic lst;
        c = cyc;
        if (f > l) begin
            done_q.push_back({16'(c + 1), 1'b1});
            end_k = 1;
        end else begin
            t = 2;
            x = '0;
            for (int a = int'(f); a <= int'(l); a++) begin
                while (!rdy(mode, t)) t++;
`ifdef REG_DUMP_CHECKSUM_EN
                lst = 1'b0;
`else
                lst = (a == int'(l));
`endif
                if (abort_k < 0 || t <= abort_k)
                    exp_q.push_back({16'(c + t), 1'b0, lst, AW'(a), rf[a]});
                x = x ^ rf[a];
                t++;
            end
`ifdef REG_DUMP_CHECKSUM_EN
            while (!rdy(mode, t)) t++;
            if (abort_k < 0)
                exp_q.push_back({16'(c + t), 1'b1, 1'b1, AW'(0), x});
            t++;
`endif
            if (abort_k < 0) begin
                done_q.push_back({16'(c + t), 1'b0});
                end_k = t;
            end else begin
                end_k = abort_k;
            end
        end
        first_addr = f;
        last_addr  = l;
        for (int k = 0; k <= end_k; k++) begin
            start         = (k == 0) || spam;
            dif.out_ready = rdy(mode, k);
            rst           = (k == abort_k);
            @(posedge clk);
            #1;
            if (k == 0) check("busy_after_start", {63'd0, busy}, {63'd0, (f <= l)});
        end
        start = 1'b0;
        if (abort_k >= 0) begin
            check("abort_valid", {63'd0, dif.out_valid}, 64'd0);
            check("abort_state", {61'd0, dbg_state}, 64'd0);
            check("abort_done",  {63'd0, done}, 64'd0);
            rst = 1'b0;
        end
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        first_addr    = '0;
        last_addr     = '0;
        dif.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = DW'(i) * 32'h1111_1111;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, dif.out_valid}, 64'd0);
        check("rst_last",  {63'd0, dif.out_last}, 64'd0);
        check("rst_csum",  {63'd0, dif.out_csum}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_err",   {63'd0, err}, 64'd0);
        check("rst_data",  {32'd0, dif.out_data}, 64'd0);
        check("rst_addr",  {59'd0, dif.out_addr}, 64'd0);
        check("rst_raddr", {59'd0, raddr}, 64'd0);
        check("rst_state", {61'd0, dbg_state}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_dump(5'd0, 5'd31, 0, 1'b0, -1);     // full dump
        rf[5] = 32'hDEAD_BEEF;
        run_dump(5'd5, 5'd5, 0, 1'b0, -1);      // single word
        run_dump(5'd3, 5'd6, 1, 1'b0, -1);      // backpressure
        run_dump(5'd10, 5'd2, 0, 1'b0, -1);     // reversed range
        run_dump(5'd0, 5'd31, 0, 1'b0, 9);      // reset while word 7 is on the bus
        run_dump(5'd0, 5'd31, 0, 1'b0, -1);     // clean dump after abort
        run_dump(5'd0, 5'd3, 0, 1'b1, -1);      // start held high throughout
        run_dump(5'd8, 5'd9, 0, 1'b0, -1);      // start in first IDLE cycle after FIN

        repeat (3) @(posedge clk);
        #1;
        check("leftover_words", 64'(exp_q.size()), 64'd0);
        check("leftover_done",  64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
